// File: rtl/rgmii_tx_arbiter_if.sv
// 8-bit AXI-stream link used for both arbiter requester ports and the MAC-facing output.
interface rgmii_tx_arbiter_if;
    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tuser;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/rgmii_tx_arbiter.sv
// Frame-atomic two-source round-robin arbiter in front of the RGMII MAC transmit stream,
// with a per-frame stall watchdog that terminates a frame abandoned by its source.
module rgmii_tx_arbiter #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk_int,
    input  logic                      rst_int,
    rgmii_tx_arbiter_if.slave         s0_axis,
    rgmii_tx_arbiter_if.slave         s1_axis,
    rgmii_tx_arbiter_if.master        m_axis,
    output logic [1:0]                grant,
    output logic [CNT_W-1:0]          s0_frames,
    output logic [CNT_W-1:0]          s1_frames,
    output logic [CNT_W-1:0]          aborts
);
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_last_q, m_last_d;
    logic                m_user_q, m_user_d;
    logic [CNT_W-1:0]    s0_frames_q, s0_frames_d;
    logic [CNT_W-1:0]    s1_frames_q, s1_frames_d;
    logic [CNT_W-1:0]    aborts_q, aborts_d;

    logic                load_c;
    logic                sel_c;
    logic                sel_valid_c;
    logic [DATA_W-1:0]   sel_data_c;
    logic                sel_last_c;
    logic                sel_user_c;
    logic                rdy_c;
    logic                accept_c;
    logic                win_c;
    logic                stall_max_c;
    logic                abort_c;
    logic                frame_inc_c;

    // Mux the granted source; grant is one-hot so bit 1 selects port 1.
    assign load_c      = !m_valid_q || m_axis.tready;
    assign sel_c       = grant_q[1];
    assign sel_valid_c = sel_c ? s1_axis.tvalid : s0_axis.tvalid;
    assign sel_data_c  = sel_c ? s1_axis.tdata  : s0_axis.tdata;
    assign sel_last_c  = sel_c ? s1_axis.tlast  : s0_axis.tlast;
    assign sel_user_c  = sel_c ? s1_axis.tuser  : s0_axis.tuser;
    assign accept_c    = rdy_c && sel_valid_c;
    assign win_c       = (s0_axis.tvalid && s1_axis.tvalid) ? !last_grant_q : s1_axis.tvalid;
    assign stall_max_c = (stall_q == STALL_W'(TIMEOUT));
    assign abort_c     = (state_q == PASS) && !accept_c && stall_max_c && load_c;

    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s0_axis.tvalid || s1_axis.tvalid) state_d = PASS;
            PASS: begin
                if (accept_c && sel_last_c) begin
                    state_d = IDLE;
                end else if (abort_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   if (accept_c && sel_last_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only the granted port sees tready; DRAIN swallows the remainder of an aborted frame.
    always_comb begin
        rdy_c          = 1'b0;
        s0_axis.tready = 1'b0;
        s1_axis.tready = 1'b0;
        case (state_q)
            PASS:    rdy_c = load_c;
            DRAIN:   rdy_c = 1'b1;
            default: rdy_c = 1'b0;
        endcase
        s0_axis.tready = rdy_c && !sel_c;
        s1_axis.tready = rdy_c &&  sel_c;
    end

    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        stall_d      = stall_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        m_user_d     = m_user_q;
        s0_frames_d  = s0_frames_q;
        s1_frames_d  = s1_frames_q;
        aborts_d     = aborts_q;
        frame_inc_c  = 1'b0;

        if (load_c) m_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (s0_axis.tvalid || s1_axis.tvalid) begin
                    grant_d = win_c ? 2'b10 : 2'b01;
                    stall_d = '0;
                end
            end
            PASS: begin
                if (accept_c) begin
                    m_valid_d = 1'b1;
                    m_data_d  = sel_data_c;
                    m_last_d  = sel_last_c;
                    m_user_d  = sel_user_c;
                    stall_d   = '0;
                    if (sel_last_c) begin
                        frame_inc_c  = 1'b1;
                        last_grant_d = sel_c;
                        grant_d      = '0;
                    end
                end else if (abort_c) begin
                    m_valid_d   = 1'b1;
                    m_data_d    = '0;
                    m_last_d    = 1'b1;
                    m_user_d    = 1'b1;
                    aborts_d    = aborts_q + CNT_W'(1);
                    frame_inc_c = 1'b1;
                end else if (!sel_valid_c && !stall_max_c) begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            DRAIN: begin
                if (accept_c && sel_last_c) begin
                    last_grant_d = sel_c;
                    grant_d      = '0;
                end
            end
            default: grant_d = '0;
        endcase

        if (frame_inc_c) begin
            if (sel_c) s1_frames_d = s1_frames_q + CNT_W'(1);
            else       s0_frames_d = s0_frames_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            grant_q      <= '0;
            last_grant_q <= 1'b1;
            stall_q      <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            m_user_q     <= 1'b0;
            s0_frames_q  <= '0;
            s1_frames_q  <= '0;
            aborts_q     <= '0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            stall_q      <= stall_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            m_user_q     <= m_user_d;
            s0_frames_q  <= s0_frames_d;
            s1_frames_q  <= s1_frames_d;
            aborts_q     <= aborts_d;
        end
    end

    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tuser  = m_user_q;
    assign grant         = grant_q;
    assign s0_frames     = s0_frames_q;
    assign s1_frames     = s1_frames_q;
    assign aborts        = aborts_q;
endmodule
